// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the carry-pipelined adder.
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int MAX_WIDTH = 64;

  // Saturation constants are built at full width and trimmed by the user.
  function automatic logic [MAX_WIDTH-1:0] satMax(input int width);
    return (MAX_WIDTH'(1) << (width - 1)) - MAX_WIDTH'(1);
  endfunction

  function automatic logic [MAX_WIDTH-1:0] satMin(input int width);
    return MAX_WIDTH'(1) << (width - 1);
  endfunction

  function automatic bit paramsOk(input int width, input int stages, input int sat);
    return (width >= 2) && (width <= MAX_WIDTH) &&
           (stages >= 1) && (stages <= width) &&
           ((width % stages) == 0) && ((sat == 0) || (sat == 1));
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational CW-bit chunk adder; one instance per pipeline stage.
module adder_slice #(
  parameter int CW = 4
) (
  input  logic [CW-1:0] a_i,
  input  logic [CW-1:0] b_i,
  input  logic          cin_i,
  output logic [CW-1:0] sum_o,
  output logic          cout_o,
  output logic          msb_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{CW{1'b0}}, cin_i};
  assign msb_o = sum_o[CW-1];

endmodule

// File: rtl/pipelined_adder.sv
// Add/subtract through STAGES carry-pipelined slices with a valid/ready handshake,
// signed overflow detection and optional saturation.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int SAT    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  if (!paramsOk(WIDTH, STAGES, SAT)) begin : g_badParams
    $error("pipelined_adder: illegal WIDTH/STAGES/SAT combination");
  end

  localparam int CW = WIDTH / STAGES;
  localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(satMax(WIDTH));
  localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(satMin(WIDTH));

  logic             en;
  op_e              op;
  logic [WIDTH-1:0] bEff;
  logic             carryIn0;

  logic             valid_q  [STAGES];
  logic             valid_d  [STAGES];
  logic             carry_q  [STAGES];
  logic             carry_d  [STAGES];
  logic             signA_q  [STAGES];
  logic             signA_d  [STAGES];
  logic             signB_q  [STAGES];
  logic             signB_d  [STAGES];
  logic [WIDTH-1:0] aSkew_q  [STAGES];
  logic [WIDTH-1:0] aSkew_d  [STAGES];
  logic [WIDTH-1:0] bSkew_q  [STAGES];
  logic [WIDTH-1:0] bSkew_d  [STAGES];
  logic [WIDTH-1:0] sum_q    [STAGES];
  logic [WIDTH-1:0] sum_d    [STAGES];
  logic             sliceMsb [STAGES];
  logic             ovf_q;
  logic             ovf_d;

  // A held result freezes the whole pipe, so nothing can overtake or be lost.
  assign en       = !valid_q[STAGES-1] || out_ready;
  assign in_ready = en;

  assign op       = op_e'(in_op);
  assign bEff     = (op == OP_SUB) ? ~in_b : in_b;
  assign carryIn0 = (op == OP_SUB) ? 1'b1 : in_cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             vIn;
    logic             cIn;
    logic             sAIn;
    logic             sBIn;
    logic [WIDTH-1:0] aIn;
    logic [WIDTH-1:0] bIn;
    logic [WIDTH-1:0] sumIn;
    logic [WIDTH-1:0] sumNext;
    logic [CW-1:0]    chunkSum;
    logic             chunkCout;

    if (k == 0) begin : g_first
      assign vIn   = in_valid;
      assign aIn   = in_a;
      assign bIn   = bEff;
      assign cIn   = carryIn0;
      assign sAIn  = in_a[WIDTH-1];
      assign sBIn  = bEff[WIDTH-1];
      assign sumIn = '0;
    end else begin : g_next
      assign vIn   = valid_q[k-1];
      assign aIn   = aSkew_q[k-1];
      assign bIn   = bSkew_q[k-1];
      assign cIn   = carry_q[k-1];
      assign sAIn  = signA_q[k-1];
      assign sBIn  = signB_q[k-1];
      assign sumIn = sum_q[k-1];
    end

    adder_slice #(
      .CW(CW)
    ) u_slice (
      .a_i   (aIn[k*CW +: CW]),
      .b_i   (bIn[k*CW +: CW]),
      .cin_i (cIn),
      .sum_o (chunkSum),
      .cout_o(chunkCout),
      .msb_o (sliceMsb[k])
    );

    assign valid_d[k] = vIn;
    assign carry_d[k] = chunkCout;
    assign signA_d[k] = sAIn;
    assign signB_d[k] = sBIn;
    assign aSkew_d[k] = aIn;
    assign bSkew_d[k] = bIn;

    // Lower chunks ride along from earlier stages; this stage fills in its own.
    always_comb begin
      sumNext = sumIn;
      sumNext[k*CW +: CW] = chunkSum;
    end

    if (k == STAGES - 1) begin : g_last
      assign ovf_d    = (sAIn == sBIn) && (sliceMsb[k] != sAIn);
      assign sum_d[k] = ((SAT != 0) && ovf_d) ? (sAIn ? SAT_NEG : SAT_POS) : sumNext;
    end else begin : g_mid
      assign sum_d[k] = sumNext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        carry_q[k] <= 1'b0;
        signA_q[k] <= 1'b0;
        signB_q[k] <= 1'b0;
        aSkew_q[k] <= '0;
        bSkew_q[k] <= '0;
        sum_q[k]   <= '0;
      end
      ovf_q <= 1'b0;
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        carry_q[k] <= carry_d[k];
        signA_q[k] <= signA_d[k];
        signB_q[k] <= signB_d[k];
        aSkew_q[k] <= aSkew_d[k];
        bSkew_q[k] <= bSkew_d[k];
        sum_q[k]   <= sum_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign out_sum   = sum_q[STAGES-1];
  assign out_cout  = carry_q[STAGES-1];
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Drives four adder configurations in lockstep and scores every result against
// an arithmetic reference model.
module tb_pipelined_adder;

  localparam int NDUT = 4;
  localparam int STG  [NDUT] = '{2, 2, 1, 8};
  localparam int SATC [NDUT] = '{0, 1, 0, 1};
  localparam int SBD  = 1024;

  logic       clk;
  logic       rst;
  logic       inValid;
  logic [7:0] inA;
  logic [7:0] inB;
  logic       inCin;
  logic       inOp;
  logic       outReady;

  logic       ir [NDUT];
  logic       ov [NDUT];
  logic [7:0] os [NDUT];
  logic       oc [NDUT];
  logic       of [NDUT];

  logic [9:0] sbMem [NDUT][SBD];
  int         head  [NDUT];
  int         tail  [NDUT];
  int         compared;
  int         mismatched;

  pipelined_adder #(.WIDTH(8), .STAGES(STG[0]), .SAT(SATC[0])) dut0 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(ir[0]), .in_a(inA), .in_b(inB),
    .in_cin(inCin), .in_op(inOp), .out_valid(ov[0]), .out_ready(outReady),
    .out_sum(os[0]), .out_cout(oc[0]), .out_ovf(of[0]));
  pipelined_adder #(.WIDTH(8), .STAGES(STG[1]), .SAT(SATC[1])) dut1 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(ir[1]), .in_a(inA), .in_b(inB),
    .in_cin(inCin), .in_op(inOp), .out_valid(ov[1]), .out_ready(outReady),
    .out_sum(os[1]), .out_cout(oc[1]), .out_ovf(of[1]));
  pipelined_adder #(.WIDTH(8), .STAGES(STG[2]), .SAT(SATC[2])) dut2 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(ir[2]), .in_a(inA), .in_b(inB),
    .in_cin(inCin), .in_op(inOp), .out_valid(ov[2]), .out_ready(outReady),
    .out_sum(os[2]), .out_cout(oc[2]), .out_ovf(of[2]));
  pipelined_adder #(.WIDTH(8), .STAGES(STG[3]), .SAT(SATC[3])) dut3 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(ir[3]), .in_a(inA), .in_b(inB),
    .in_cin(inCin), .in_op(inOp), .out_valid(ov[3]), .out_ready(outReady),
    .out_sum(os[3]), .out_cout(oc[3]), .out_ovf(of[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Signed/unsigned integer arithmetic on whole operands: returns {sum, cout, ovf}.
  function automatic logic [9:0] refModel(input logic [7:0] a, input logic [7:0] b,
                                          input logic cin, input logic op, input int sat);
    int sa, sb, r;
    logic [7:0] s;
    logic co, ovf;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!op) begin
      r  = sa + sb + int'(cin);
      co = (int'(a) + int'(b) + int'(cin)) > 255;
    end else begin
      r  = sa - sb;
      co = (a >= b);
    end
    ovf = (r > 127) || (r < -128);
    s   = 8'(r);
    if ((sat != 0) && ovf) s = a[7] ? 8'h80 : 8'h7F;
    return {s, co, ovf};
  endfunction

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs just before the clock edge with this cycle's inputs already applied.
  task automatic checkOutput();
    logic [9:0] expv;
    for (int i = 0; i < NDUT; i++) begin
      if (ov[i] && outReady) begin
        checkEq($sformatf("dut%0d_pending", i), 32'(tail[i] != head[i]), 32'd1);
        if (tail[i] != head[i]) begin
          expv = sbMem[i][head[i] % SBD];
          checkEq($sformatf("dut%0d_result", i), 32'({os[i], oc[i], of[i]}), 32'(expv));
          head[i]++;
        end
      end
      if (inValid && ir[i]) begin
        sbMem[i][tail[i] % SBD] = refModel(inA, inB, inCin, inOp, SATC[i]);
        tail[i]++;
      end
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] a, input logic [7:0] b,
                               input logic cin, input logic op, input logic rdy);
    inValid  = v;
    inA      = a;
    inB      = b;
    inCin    = cin;
    inOp     = op;
    outReady = rdy;
    #1;
    checkOutput();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic checkDrained(input string tag);
    for (int i = 0; i < NDUT; i++)
      checkEq($sformatf("%s_dut%0d_left", tag, i), 32'(tail[i] - head[i]), 32'd0);
  endtask

  task automatic directed(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic op, input logic [7:0] expSum,
                          input logic expCout, input logic expOvf, input logic [7:0] expSat);
    applyStimulus(1'b1, a, b, cin, op, 1'b1);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    checkEq({tag, "_valid"}, 32'(ov[0]), 32'd1);
    checkEq({tag, "_sum"}, 32'(os[0]), 32'(expSum));
    checkEq({tag, "_cout"}, 32'(oc[0]), 32'(expCout));
    checkEq({tag, "_ovf"}, 32'(of[0]), 32'(expOvf));
    checkEq({tag, "_satSum"}, 32'(os[1]), 32'(expSat));
    checkEq({tag, "_satOvf"}, 32'(of[1]), 32'(expOvf));
    idle(8);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    for (int i = 0; i < NDUT; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    rst      = 1'b1;
    inValid  = 1'b0;
    inA      = 8'h00;
    inB      = 8'h00;
    inCin    = 1'b0;
    inOp     = 1'b0;
    outReady = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    $display("[TB] reset state");
    for (int i = 0; i < NDUT; i++) begin
      checkEq($sformatf("rst_dut%0d_valid", i), 32'(ov[i]), 32'd0);
      checkEq($sformatf("rst_dut%0d_sum", i), 32'(os[i]), 32'd0);
      checkEq($sformatf("rst_dut%0d_cout", i), 32'(oc[i]), 32'd0);
      checkEq($sformatf("rst_dut%0d_ovf", i), 32'(of[i]), 32'd0);
      checkEq($sformatf("rst_dut%0d_ready", i), 32'(ir[i]), 32'd1);
    end

    $display("[TB] latency and 7F+01");
    applyStimulus(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      for (int i = 0; i < NDUT; i++)
        checkEq($sformatf("lat_dut%0d_c%0d", i, c), 32'(ov[i]), 32'(c == STG[i]));
      if (c == 2) begin
        checkEq("add7F_sum", 32'(os[0]), 32'h80);
        checkEq("add7F_cout", 32'(oc[0]), 32'd0);
        checkEq("add7F_ovf", 32'(of[0]), 32'd1);
        checkEq("add7F_satSum", 32'(os[1]), 32'h7F);
        checkEq("add7F_satOvf", 32'(of[1]), 32'd1);
      end
      idle(1);
    end

    $display("[TB] directed corner cases");
    directed("addFF", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    directed("add0Fc", 8'h0F, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0, 8'h10);
    directed("sub00", 8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 8'hFF);
    directed("sub80", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 8'h80);
    checkDrained("directed");

    $display("[TB] backpressure");
    applyStimulus(1'b1, 8'h10, 8'h03, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h20, 8'h03, 1'b0, 1'b0, 1'b1);
    for (int s = 0; s < 3; s++) begin
      applyStimulus(1'b1, 8'h30, 8'h03, 1'b0, 1'b0, 1'b0);
      checkEq($sformatf("stall%0d_ready", s), 32'(ir[0]), 32'd0);
      checkEq($sformatf("stall%0d_valid", s), 32'(ov[0]), 32'd1);
      checkEq($sformatf("stall%0d_sum", s), 32'(os[0]), 32'h13);
    end
    applyStimulus(1'b1, 8'h30, 8'h03, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h40, 8'h03, 1'b0, 1'b0, 1'b1);
    idle(10);
    checkDrained("stall");

    $display("[TB] reset with beats in flight");
    applyStimulus(1'b1, 8'h55, 8'h11, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h66, 8'h22, 1'b0, 1'b1, 1'b1);
    rst     = 1'b1;
    inValid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NDUT; i++) head[i] = tail[i];
    for (int i = 0; i < NDUT; i++) begin
      checkEq($sformatf("midrst_dut%0d_valid", i), 32'(ov[i]), 32'd0);
      checkEq($sformatf("midrst_dut%0d_ready", i), 32'(ir[i]), 32'd1);
    end
    idle(10);
    checkDrained("midrst");

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++)
      applyStimulus(1'($urandom_range(0, 9) < 7), 8'($urandom), 8'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
    idle(20);
    checkDrained("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised successor to the team's 1-bit registered half adder.
- Adds or subtracts two WIDTH-bit operands through a carry-pipelined chain of STAGES slices.
- Valid/ready handshake with backpressure, optional carry-in, signed overflow flag and optional saturation.
- Used as the shared arithmetic primitive in datapaths and as a formal-verification (SBY) target.

Parameters:
- WIDTH, 8: operand/result width in bits; must be divisible by STAGES; WIDTH >= 2.
- STAGES, 2: pipeline stages; each stage resolves WIDTH/STAGES bits; 1 <= STAGES <= WIDTH.
- SAT, 0: 1 = clamp result on signed overflow; 0 = wrap.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  pipeline can accept a beat this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in; used in ADD only.
- in_op  in  1  0 = ADD (a+b+cin), 1 = SUB (a-b).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  WIDTH  result.
- out_cout  out  1  carry-out; in SUB, 1 = no borrow.
- out_ovf  out  1  signed overflow of the unsaturated result.

Behaviour:
- Reset (rst=1 at a clk edge): all stage valid bits 0; out_valid=0, out_sum=0, out_cout=0, out_ovf=0; in_ready=1 from the first cycle after reset. A reset mid-operation discards all in-flight beats.
- Transfers: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Stall: global enable en = !out_valid || out_ready. in_ready = en (combinational). When en=0, every pipeline register holds.
- Latency: exactly STAGES cycles from input transfer to out_valid with no stall. Throughput is 1 beat/cycle when out_ready is held at 1.
- Operand prep at entry: b_eff = SUB ? ~in_b : in_b; c0 = SUB ? 1 : in_cin.
- Slice k (k = 0..STAGES-1), bits [k*W/S +: W/S]:
  - computes its chunk with the carry registered from slice k-1;
  - untouched upper chunks travel through skew registers;
  - already-resolved lower result chunks travel through deskew registers so all bits align at the output.
- Sign tracking: the MSB signs of a and b_eff travel with the beat and feed the overflow check.
- Overflow: ovf = (sign_a == sign_b_eff) && (sum_msb != sign_a).
- SAT=1 and ovf=1: out_sum = sign_a ? {1'b1, 0...} (most negative) : {1'b0, 1...} (most positive). out_ovf still reports 1; out_cout is unaffected.
- STAGES=1 degenerates to a single registered adder with the same handshake.
- in_op and in_cin are sampled only on input transfer; values on cycles without a transfer have no effect.
- Bubbles (in_valid=0) propagate as invalid stages; result data under out_valid=0 is don't-care, but must not be X after reset.
- Formal properties:
  - out_sum, out_cout, out_ovf stay stable while out_valid && !out_ready;
  - beat count in = beat count out + in-flight count, never exceeding STAGES.

Decomposition:
- adder_pkg:
  - op_e enum (OP_ADD=1'b0, OP_SUB=1'b1);
  - localparam function for the saturation constants;
  - elaboration-time checks on WIDTH % STAGES and the parameter ranges above.
- Sub-module adder_slice: combinational CW-bit chunk adder (a, b, cin -> sum, cout) plus msb/sign outputs for the last slice.
- pipelined_adder instantiates STAGES adder_slice instances and owns the valid, skew and deskew registers and the handshake.

Test Plan (WIDTH=8, STAGES=2 unless stated):
- Reset then ADD 8'h7F + 8'h01, cin=0, out_ready=1 -> out_valid high exactly 2 cycles later; sum=8'h80, cout=0, ovf=1. With SAT=1: sum=8'h7F, ovf=1.
- ADD 8'hFF + 8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0. ADD 8'h0F + 8'h00, cin=1 -> sum=8'h10, exercising the carry across the slice boundary.
- SUB 8'h00 - 8'h01 -> sum=8'hFF, cout=0, ovf=0. SUB 8'h80 - 8'h01 -> sum=8'h7F, ovf=1; with SAT=1 -> sum=8'h80.
- Back-to-back 4 beats, out_ready=0 from the cycle the first result appears for 3 cycles -> in_ready=0 during the stall, outputs hold the first result, no beat lost or duplicated, order preserved after out_ready=1.
- rst asserted for 1 cycle with 2 beats in flight -> out_valid=0 the next cycle, no stale result ever emerges, in_ready=1.
- STAGES=1 and STAGES=8, random a/b/op/cin with random out_ready, compared against a reference model -> all results match, latency equals STAGES.
